// File: rtl/ram2_sram_model_if.sv
// ram2_sram_model_if
//   Pin bundle for the RAM2 asynchronous-SRAM interface.
//   master : controller side (drives address and strobes, shares data bus)
//   slave  : SRAM side (samples address and strobes, shares data bus)
//   sram_addr  ADDR_W  word address
//   sram_data  DATA_W  shared tri-state data bus
//   sram_en_n  1       chip enable, active-low
//   sram_oe_n  1       output enable, active-low
//   sram_we_n  1       write enable, active-low
interface ram2_sram_model_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] sram_addr;
  wire  [DATA_W-1:0] sram_data;
  logic              sram_en_n;
  logic              sram_oe_n;
  logic              sram_we_n;

  modport master (
    output sram_addr, sram_en_n, sram_oe_n, sram_we_n,
    inout  sram_data
  );

  modport slave (
    input  sram_addr, sram_en_n, sram_oe_n, sram_we_n,
    inout  sram_data
  );
endinterface

// File: rtl/ram2_sram_model.sv
// ram2_sram_model
//   Clocked stand-in for the external RAM2 SRAM chip. Pins are sampled once
//   per clk; reads drive the shared bus READ_LAT cycles after the FSM latches
//   the read address, writes commit on the sampled WE rising edge.
//   Ports:
//     clk           system clock
//     rst           asynchronous reset, active-low (memory contents kept)
//     bus           ram2_sram_model_if.slave pin bundle
//     wr_count      committed write count, wraps
//     last_wr_addr  array index of the most recent committed write
//     rd_valid      high while the model drives valid read data
//   Optional (define SRAM_MODEL_CHECK_EN):
//     proto_err     sticky protocol error flag
//     err_code      first error cause: 1 OE/WE overlap, 2 bus contention,
//                   3 WE rising while EN high
module ram2_sram_model #(
  parameter int ADDR_W   = 18,
  parameter int DEPTH_W  = 10,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  ram2_sram_model_if.slave   bus,
  output logic [15:0]        wr_count,
  output logic [DEPTH_W-1:0] last_wr_addr,
  output logic               rd_valid
`ifdef SRAM_MODEL_CHECK_EN
  ,
  output logic               proto_err,
  output logic [1:0]         err_code
`endif
);

  typedef enum logic [1:0] {IDLE, READ_WAIT, READ_DRIVE, WRITE_ARM} state_t;

  localparam logic [3:0] LAT_INIT = 4'(READ_LAT - 1);

  state_t state, state_next;

  // Sampled pins and previous sampled strobes
  logic              s_en, s_oe, s_we, p_en, p_we;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_data;

  logic [3:0]         lat_cnt, lat_cnt_next;
  logic [ADDR_W-1:0]  rd_addr, rd_addr_next;
  logic [DEPTH_W-1:0] wa, wa_next;
  logic [DATA_W-1:0]  wd, wd_next;
  logic               drv_q, drv_next;
  logic [15:0]        wr_count_next;
  logic [DEPTH_W-1:0] last_wr_addr_next;
  logic               mem_we, fetch;
  logic               drive_en;

  logic [DATA_W-1:0] mem [2**DEPTH_W];
  logic [DATA_W-1:0] rd_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_en   <= 1'b1;
      s_oe   <= 1'b1;
      s_we   <= 1'b1;
      p_en   <= 1'b1;
      p_we   <= 1'b1;
      s_addr <= '0;
      s_data <= '0;
    end else begin
      s_en   <= bus.sram_en_n;
      s_oe   <= bus.sram_oe_n;
      s_we   <= bus.sram_we_n;
      p_en   <= s_en;
      p_we   <= s_we;
      s_addr <= bus.sram_addr;
      s_data <= bus.sram_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      lat_cnt      <= '0;
      rd_addr      <= '0;
      wa           <= '0;
      wd           <= '0;
      drv_q        <= 1'b0;
      wr_count     <= '0;
      last_wr_addr <= '0;
    end else begin
      state        <= state_next;
      lat_cnt      <= lat_cnt_next;
      rd_addr      <= rd_addr_next;
      wa           <= wa_next;
      wd           <= wd_next;
      drv_q        <= drv_next;
      wr_count     <= wr_count_next;
      last_wr_addr <= last_wr_addr_next;
    end
  end

  always_comb begin
    state_next        = state;
    lat_cnt_next      = lat_cnt;
    rd_addr_next      = rd_addr;
    wa_next           = wa;
    wd_next           = wd;
    drv_next          = drv_q;
    wr_count_next     = wr_count;
    last_wr_addr_next = last_wr_addr;
    mem_we            = 1'b0;
    fetch             = 1'b0;

    case (state)
      IDLE: begin
        // Write wins when OE and WE are both low
        if (!s_en && !s_we) begin
          state_next = WRITE_ARM;
          wa_next    = s_addr[DEPTH_W-1:0];
          wd_next    = s_data;
        end else if (!s_en && !s_oe) begin
          state_next   = READ_WAIT;
          lat_cnt_next = LAT_INIT;
          rd_addr_next = s_addr;
        end
      end

      READ_WAIT, READ_DRIVE: begin
        if (s_en) begin
          drv_next   = 1'b0;
          state_next = IDLE;
        end else if (!s_we) begin
          drv_next   = 1'b0;
          state_next = WRITE_ARM;
          wa_next    = s_addr[DEPTH_W-1:0];
          wd_next    = s_data;
        end else if (s_oe) begin
          drv_next   = 1'b0;
          state_next = IDLE;
        end else if (s_addr != rd_addr) begin
          // Full-width compare: any address change restarts the access
          drv_next     = 1'b0;
          state_next   = READ_WAIT;
          lat_cnt_next = LAT_INIT;
          rd_addr_next = s_addr;
        end else if (state == READ_WAIT) begin
          if (lat_cnt == 4'd0) begin
            fetch      = 1'b1;
            drv_next   = 1'b1;
            state_next = READ_DRIVE;
          end else begin
            lat_cnt_next = lat_cnt - 4'd1;
          end
        end
      end

      WRITE_ARM: begin
        if (s_we) begin
          // Commit only on a genuine rise with EN still low the cycle before
          if (!p_we && !p_en) begin
            mem_we            = 1'b1;
            wr_count_next     = wr_count + 16'd1;
            last_wr_addr_next = wa;
          end
          state_next = IDLE;
        end else if (s_en) begin
          state_next = IDLE;
        end else begin
          wa_next = s_addr[DEPTH_W-1:0];
          wd_next = s_data;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // Storage: no reset so the array maps onto block RAM and survives rst
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[wa] <= wd;
    if (fetch)
      rd_data <= mem[rd_addr[DEPTH_W-1:0]];
  end

  // Raw pins gate the drive so the bus lets go without waiting for clk
  assign drive_en      = drv_q & ~bus.sram_oe_n & ~bus.sram_en_n & bus.sram_we_n;
  assign bus.sram_data = drive_en ? rd_data : 'z;
  assign rd_valid      = drive_en;

`ifdef SRAM_MODEL_CHECK_EN
  // s_drv lines up with s_data so only a fully driven cycle is compared
  logic s_drv;
  logic err_overlap, err_contention, err_we_rise;

  assign err_overlap    = !s_en && !s_oe && !s_we;
  assign err_contention = s_drv && (s_data != rd_data);
  assign err_we_rise    = s_we && !p_we && s_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_drv     <= 1'b0;
      proto_err <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      s_drv <= drive_en;
      if (!proto_err) begin
        if (err_overlap) begin
          proto_err <= 1'b1;
          err_code  <= 2'd1;
        end else if (err_contention) begin
          proto_err <= 1'b1;
          err_code  <= 2'd2;
        end else if (err_we_rise) begin
          proto_err <= 1'b1;
          err_code  <= 2'd3;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_ram2_sram_model.sv
// tb_ram2_sram_model
//   Directed bench for ram2_sram_model: write/read, latency, address change,
//   aliasing, aborted write, back-to-back, reset during a read and (when
//   SRAM_MODEL_CHECK_EN is defined) the OE/WE overlap error.
module tb_ram2_sram_model;

  logic        clk;
  logic        rst;
  logic        tb_drv;
  logic [15:0] tb_wdata;
  logic [15:0] wr_count;
  logic [9:0]  last_wr_addr;
  logic        rd_valid;
`ifdef SRAM_MODEL_CHECK_EN
  logic        proto_err;
  logic [1:0]  err_code;
`endif

  int tests_run;
  int tests_failed;

  ram2_sram_model_if #(.ADDR_W(18), .DATA_W(16)) bus ();

  assign bus.sram_data = tb_drv ? tb_wdata : 'z;

  ram2_sram_model #(
    .ADDR_W(18), .DEPTH_W(10), .DATA_W(16), .READ_LAT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .wr_count(wr_count),
    .last_wr_addr(last_wr_addr),
    .rd_valid(rd_valid)
`ifdef SRAM_MODEL_CHECK_EN
    ,
    .proto_err(proto_err),
    .err_code(err_code)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_idle(input int n);
    @(negedge clk);
    bus.sram_en_n = 1'b1;
    bus.sram_oe_n = 1'b1;
    bus.sram_we_n = 1'b1;
    tb_drv        = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // WE low for three cycles, WE rises, EN rises one cycle later
  task automatic do_write(input logic [17:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.sram_addr = a;
    tb_wdata      = d;
    tb_drv        = 1'b1;
    bus.sram_oe_n = 1'b1;
    bus.sram_en_n = 1'b0;
    bus.sram_we_n = 1'b0;
    repeat (3) @(negedge clk);
    bus.sram_we_n = 1'b1;
    @(negedge clk);
    bus.sram_en_n = 1'b1;
    tb_drv        = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] write addr=%05h data=%04h wr_count=%0d", a, d, wr_count);
  endtask

  task automatic start_read(input logic [17:0] a);
    @(negedge clk);
    bus.sram_addr = a;
    bus.sram_we_n = 1'b1;
    bus.sram_en_n = 1'b0;
    bus.sram_oe_n = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus.sram_addr = '0;
    bus.sram_en_n = 1'b1;
    bus.sram_oe_n = 1'b1;
    bus.sram_we_n = 1'b1;
    tb_drv   = 1'b0;
    tb_wdata = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_rd_valid: got %b expected 0", rd_valid);
    end
    tests_run++;
    if (wr_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_wr_count: got %0d expected 0", wr_count);
    end
    tests_run++;
    if (last_wr_addr !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_last_wr_addr: got %0d expected 0", last_wr_addr);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    $display("[TB] reset released");
  endtask

  task automatic test_write_read;
    do_write(18'h00005, 16'hBEEF);
    tests_run++;
    if (wr_count !== 16'd1 || last_wr_addr !== 10'd5) begin
      tests_failed++;
      $display("FAIL write_commit: got count=%0d addr=%0d expected count=1 addr=5", wr_count, last_wr_addr);
    end
    do_write(18'h00006, 16'h1234);
    tests_run++;
    if (wr_count !== 16'd2 || last_wr_addr !== 10'd6) begin
      tests_failed++;
      $display("FAIL write_commit2: got count=%0d addr=%0d expected count=2 addr=6", wr_count, last_wr_addr);
    end
    start_read(18'h00005);
    repeat (3) @(negedge clk);
    tests_run++;
    if (rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_early: got rd_valid=%b expected 0", rd_valid);
    end
    @(negedge clk);
    tests_run++;
    if (rd_valid !== 1'b1 || bus.sram_data !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL read_data: got valid=%b data=%04h expected valid=1 data=beef", rd_valid, bus.sram_data);
    end
    $display("[TB] read addr=00005 data=%04h", bus.sram_data);
    bus.sram_oe_n = 1'b1;
    #1;
    tests_run++;
    if (rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL oe_release: got rd_valid=%b expected 0", rd_valid);
    end
    set_idle(2);
  endtask

  task automatic test_addr_change;
    start_read(18'h00005);
    repeat (4) @(negedge clk);
    bus.sram_addr = 18'h00006;
    @(negedge clk);
    tests_run++;
    if (rd_valid !== 1'b1 || bus.sram_data !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL addr_chg_hold: got valid=%b data=%04h expected valid=1 data=beef", rd_valid, bus.sram_data);
    end
    @(negedge clk);
    tests_run++;
    if (rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL addr_chg_release: got rd_valid=%b expected 0", rd_valid);
    end
    @(negedge clk);
    tests_run++;
    if (rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL addr_chg_wait: got rd_valid=%b expected 0", rd_valid);
    end
    @(negedge clk);
    tests_run++;
    if (rd_valid !== 1'b1 || bus.sram_data !== 16'h1234) begin
      tests_failed++;
      $display("FAIL addr_chg_data: got valid=%b data=%04h expected valid=1 data=1234", rd_valid, bus.sram_data);
    end
    $display("[TB] read addr=00006 after change data=%04h", bus.sram_data);
    set_idle(2);
  endtask

  task automatic test_alias;
    do_write(18'h00403, 16'hA5A5);
    tests_run++;
    if (wr_count !== 16'd3 || last_wr_addr !== 10'd3) begin
      tests_failed++;
      $display("FAIL alias_commit: got count=%0d addr=%0d expected count=3 addr=3", wr_count, last_wr_addr);
    end
    start_read(18'h00003);
    repeat (4) @(negedge clk);
    tests_run++;
    if (rd_valid !== 1'b1 || bus.sram_data !== 16'hA5A5) begin
      tests_failed++;
      $display("FAIL alias_read: got valid=%b data=%04h expected valid=1 data=a5a5", rd_valid, bus.sram_data);
    end
    $display("[TB] read addr=00003 data=%04h", bus.sram_data);
    set_idle(2);
  endtask

  task automatic test_abort;
    @(negedge clk);
    bus.sram_addr = 18'h00003;
    tb_wdata      = 16'h1111;
    tb_drv        = 1'b1;
    bus.sram_en_n = 1'b0;
    bus.sram_we_n = 1'b0;
    repeat (2) @(negedge clk);
    bus.sram_en_n = 1'b1;
    repeat (2) @(negedge clk);
    bus.sram_we_n = 1'b1;
    tb_drv        = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] aborted write addr=00003 data=1111");
    tests_run++;
    if (wr_count !== 16'd3) begin
      tests_failed++;
      $display("FAIL abort_count: got %0d expected 3", wr_count);
    end
    start_read(18'h00003);
    repeat (4) @(negedge clk);
    tests_run++;
    if (rd_valid !== 1'b1 || bus.sram_data !== 16'hA5A5) begin
      tests_failed++;
      $display("FAIL abort_read: got valid=%b data=%04h expected valid=1 data=a5a5", rd_valid, bus.sram_data);
    end
    set_idle(2);
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    bus.sram_addr = 18'h00009;
    tb_wdata      = 16'h7777;
    tb_drv        = 1'b1;
    bus.sram_en_n = 1'b0;
    bus.sram_we_n = 1'b0;
    repeat (3) @(negedge clk);
    bus.sram_we_n = 1'b1;
    @(negedge clk);
    tb_drv        = 1'b0;
    bus.sram_oe_n = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if (rd_valid !== 1'b1 || bus.sram_data !== 16'h7777) begin
      tests_failed++;
      $display("FAIL b2b_read: got valid=%b data=%04h expected valid=1 data=7777", rd_valid, bus.sram_data);
    end
    tests_run++;
    if (wr_count !== 16'd4 || last_wr_addr !== 10'd9) begin
      tests_failed++;
      $display("FAIL b2b_commit: got count=%0d addr=%0d expected count=4 addr=9", wr_count, last_wr_addr);
    end
    $display("[TB] back-to-back write/read addr=00009 data=%04h", bus.sram_data);
    set_idle(2);
  endtask

  task automatic test_reset_during_read;
    start_read(18'h00005);
    repeat (4) @(negedge clk);
    tests_run++;
    if (rd_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_pre_drive: got rd_valid=%b expected 1", rd_valid);
    end
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if (rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_release: got rd_valid=%b expected 0", rd_valid);
    end
    // Bench drives a distinct value: it must appear unaltered on the bus
    tb_wdata = 16'h0F0F;
    tb_drv   = 1'b1;
    #1;
    tests_run++;
    if (bus.sram_data !== 16'h0F0F) begin
      tests_failed++;
      $display("FAIL rst_bus_free: got %04h expected 0f0f", bus.sram_data);
    end
    tb_drv = 1'b0;
    tests_run++;
    if (wr_count !== 16'd0 || last_wr_addr !== 10'd0) begin
      tests_failed++;
      $display("FAIL rst_counters: got count=%0d addr=%0d expected 0 0", wr_count, last_wr_addr);
    end
    bus.sram_en_n = 1'b1;
    bus.sram_oe_n = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    start_read(18'h00005);
    repeat (4) @(negedge clk);
    tests_run++;
    if (rd_valid !== 1'b1 || bus.sram_data !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL rst_mem_kept: got valid=%b data=%04h expected valid=1 data=beef", rd_valid, bus.sram_data);
    end
    $display("[TB] reset during read, readback addr=00005 data=%04h", bus.sram_data);
    set_idle(2);
  endtask

`ifdef SRAM_MODEL_CHECK_EN
  task automatic test_proto_check;
    tests_run++;
    if (proto_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL proto_clean: got proto_err=%b expected 0", proto_err);
    end
    @(negedge clk);
    bus.sram_addr = 18'h00001;
    bus.sram_en_n = 1'b0;
    bus.sram_oe_n = 1'b0;
    bus.sram_we_n = 1'b0;
    repeat (2) @(negedge clk);
    bus.sram_en_n = 1'b1;
    @(negedge clk);
    bus.sram_we_n = 1'b1;
    bus.sram_oe_n = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (proto_err !== 1'b1 || err_code !== 2'd1) begin
      tests_failed++;
      $display("FAIL proto_overlap: got err=%b code=%0d expected err=1 code=1", proto_err, err_code);
    end
    $display("[TB] overlap check proto_err=%b err_code=%0d", proto_err, err_code);
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if (proto_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL proto_clear: got proto_err=%b expected 0", proto_err);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_write_read();
    test_addr_change();
    test_alias();
    test_abort();
    test_back_to_back();
    test_reset_during_read();
`ifdef SRAM_MODEL_CHECK_EN
    test_proto_check();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ram2_sram_model.md
Name: ram2_sram_model

Overview:
- Clocked responder for the RAM2 asynchronous-SRAM pin interface: Ram2Addr, Ram2Data, Ram2OE, Ram2WE and Ram2EN, all active-low strobes.
- Emulates the external SRAM chip so the RAM2 controller can be exercised in simulation and on-board loopback without real memory.
- Stores words in an internal array, returns read data on the shared tri-state bus after a programmable latency, and commits writes on the WE rising edge.

Parameters:
- ADDR_W, 18, width of the sram_addr bus.
- DEPTH_W, 10, log2 of implemented words; sram_addr[DEPTH_W-1:0] indexes the array, upper bits are ignored (aliasing).
- DATA_W, 16, data word width.
- READ_LAT, 2, clk cycles from a qualified read (or address change) to bus drive; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- sram_addr  in  ADDR_W  address from the controller.
- sram_data  inout  DATA_W  shared data bus; driven only during a qualified read.
- sram_en_n  in  1  chip enable, active-low.
- sram_oe_n  in  1  output enable, active-low.
- sram_we_n  in  1  write enable, active-low.
- wr_count  out  16  number of committed writes, wraps at 16'hffff->0.
- last_wr_addr  out  DEPTH_W  index of the most recent committed write.
- rd_valid  out  1  high while the model is driving valid data.

Behaviour:
- Pin sampling: en/oe/we/addr/data are registered once per clk (s_*). Previous strobe values are kept for edge detection.
- Reset (rst low, async): state IDLE, drive register cleared, lat_cnt=0, wr_count=0, last_wr_addr=0, rd_valid=0, sram_data=Z. Array contents are NOT cleared. Any pending write is discarded.
- Bus drive: sram_data = rd_data when drv_q && !sram_oe_n && !sram_en_n && sram_we_n; otherwise Z.
  - The gating terms are combinational, so the bus releases in the same instant OE/EN rises or WE falls.
- rd_valid = the same enable expression.
- State IDLE:
  - s_en=0, s_we=0 -> WRITE_ARM.
  - Else s_en=0, s_oe=0 -> READ_WAIT with lat_cnt=READ_LAT-1 and rd_addr latched.
- State READ_WAIT: lat_cnt decrements each cycle.
  - At 0: rd_data=mem[rd_addr], drv_q=1 -> READ_DRIVE.
  - Total latency from the sampled OE fall to drive = READ_LAT cycles after the sample edge.
- State READ_DRIVE:
  - Holds drive while s_en=0 and s_oe=0.
  - Address change (s_addr != rd_addr): drv_q=0, re-latch, -> READ_WAIT.
  - s_oe or s_en high: drv_q=0 -> IDLE.
  - s_we low: drv_q=0 -> WRITE_ARM.
- State WRITE_ARM: each cycle with s_we=0, capture wa=s_addr index and wd=s_data.
  - On s_we rising (prev 0, now 1) while s_en was 0: mem[wa]<=wd, wr_count+1, last_wr_addr<=wa -> IDLE.
  - If s_en rises before WE rises: write aborted, no commit -> IDLE.
- Simultaneous OE and WE low: write takes priority; never drive.
- Back-to-back: a write followed one cycle later by a read of the same address returns the new data. The array write precedes the READ_WAIT fetch by at least one cycle.
- Stuck strobes: WE held low indefinitely commits exactly once, on the eventual rise.

Optional Feature:
- Macro SRAM_MODEL_CHECK_EN adds output proto_err (1 bit, sticky until reset).
- It sets on any of:
  - OE and WE sampled low together with EN low;
  - sram_data driven externally (non-Z) while drv_q=1;
  - WE rising while EN high.
- It also adds output err_code[1:0] giving the first error cause: 1 = OE/WE overlap, 2 = contention, 3 = WE rising while EN high.
- Without the macro: no checking logic, no proto_err or err_code ports.

Test Plan:
- Reset, then EN=0, WE pulse low 3 cycles with addr=0x0005, data=0xBEEF -> wr_count=1, last_wr_addr=5.
  - Then OE=0 addr=0x0005 -> after READ_LAT=2 cycles sram_data=0xBEEF, rd_valid=1.
- Read in progress, addr changes 0x0005->0x0006 (mem[6]=0x1234) -> bus released next cycle, 0x1234 driven 2 cycles later.
- Aliasing: write 0xA5A5 to addr 0x00403 (DEPTH_W=10) -> read of addr 0x003 returns 0xA5A5.
- WE low then EN rises before WE rises -> no commit; wr_count unchanged; previous mem value read back.
- rst asserted during READ_DRIVE -> sram_data=Z immediately, rd_valid=0. After reset, stored 0xBEEF still readable.
- With SRAM_MODEL_CHECK_EN: OE=0 and WE=0 together with EN=0 -> proto_err=1, err_code=1, held until rst.
